// File: rtl/im_req_scheduler_pkg.sv
// Shared definitions for the item-memory request scheduler.
//
// Contents:
//   HVDimensionDef  - default hypervector width
//   NumTotImDef     - default number of item-memory entries
//   ImAddrMaxWidth  - width of the address fields inside im_req_t. Any
//                     concrete ImAddrWidth must fit in it.
//   im_req_t        - one lookup request: CiM select for port A, plus the
//                     port A and port B addresses.
package im_req_scheduler_pkg;

    localparam int unsigned HVDimensionDef = 512;
    localparam int unsigned NumTotImDef    = 1024;
    localparam int unsigned ImAddrMaxWidth = 32;

    // The address fields are sized for the widest legal memory. The scheduler
    // zero-extends requester addresses into this struct and truncates them
    // back to ImAddrWidth on the item-memory side.
    typedef struct packed {
        logic                      cim;
        logic [ImAddrMaxWidth-1:0] a_addr;
        logic [ImAddrMaxWidth-1:0] b_addr;
    } im_req_t;

endpackage

// File: rtl/im_req_scheduler_rr_arbiter.sv
// Round-robin arbiter.
//
// The grant is combinational from req_i. The search starts one position after
// the most recently granted requester and wraps around. The pointer moves only
// on a cycle that issues a grant. Reset puts the pointer at NumReq-1, so
// requester 0 has first priority.
//
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset
//   req_i  - request vector (NumReq)
//   gnt_o  - one-hot grant, or zero when there are no requests (NumReq)
module rr_arbiter #(
    parameter int unsigned NumReq = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NumReq-1:0] req_i,
    output logic [NumReq-1:0] gnt_o
);

    localparam int unsigned PtrWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [PtrWidth-1:0] last_q, last_d;
    logic [PtrWidth-1:0] cand_idx;
    logic                found;

    always_comb begin
        gnt_o    = '0;
        last_d   = last_q;
        cand_idx = '0;
        found    = 1'b0;
        // Visit last+1, last+2, ... last+NumReq (mod NumReq). The last visit
        // is last_q itself, so a lone requester can be granted twice in a row.
        for (int unsigned k = 1; k <= NumReq; k++) begin
            cand_idx = PtrWidth'((32'(last_q) + k) % NumReq);
            if (!found && req_i[cand_idx]) begin
                found           = 1'b1;
                gnt_o[cand_idx] = 1'b1;
                last_d          = cand_idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= PtrWidth'(NumReq - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/im_req_scheduler.sv
// Item-memory request scheduler.
//
// Several requesters share one dual-port item memory. Each cycle, at most one
// eligible requester is granted. Its request fields drive the memory address
// lines combinationally. The memory data is captured into that requester's
// private response buffer on the same clock edge.
//
// Ports:
//   clk_i, rst_i          - clock, synchronous active-high reset
//   en_i                  - allows new grants (draining is unaffected)
//   req_valid_i/_ready_o  - request handshake; ready is the grant
//   req_cim_i             - port A reads CiM instead of IM
//   req_a_addr_i/_b_      - per-requester port A/B addresses
//   rsp_valid_o/_ready_i  - response buffer handshake
//   rsp_a_o, rsp_b_o      - buffered port A/B hypervectors
//   im_port_a_cim_o       - CiM select to the item memory
//   im_a_addr_o/_b_       - addresses to the item memory
//   im_a_i, im_b_i        - item memory data (combinational)
//   busy_o                - a response is pending or a request is eligible
//   lookup_cnt_o          - saturating count of granted lookups
//
// Handshake: a request moves when req_valid_i[i] & req_ready_o[i]. A response
// moves when rsp_valid_o[i] & rsp_ready_i[i]. A requester can be granted only
// if its buffer is empty or drains in the same cycle, so responses are never
// overwritten before they are consumed.
module im_req_scheduler
    import im_req_scheduler_pkg::*;
#(
    parameter int unsigned HVDimension = HVDimensionDef,
    parameter int unsigned NumTotIm    = NumTotImDef,
    parameter int unsigned NumReq      = 2,
    parameter int unsigned CntWidth    = 32,
    localparam int unsigned ImAddrWidth = $clog2(NumTotIm)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   en_i,
    input  logic [NumReq-1:0]                      req_valid_i,
    output logic [NumReq-1:0]                      req_ready_o,
    input  logic [NumReq-1:0]                      req_cim_i,
    input  logic [NumReq-1:0][ImAddrWidth-1:0]     req_a_addr_i,
    input  logic [NumReq-1:0][ImAddrWidth-1:0]     req_b_addr_i,
    output logic [NumReq-1:0]                      rsp_valid_o,
    input  logic [NumReq-1:0]                      rsp_ready_i,
    output logic [NumReq-1:0][HVDimension-1:0]     rsp_a_o,
    output logic [NumReq-1:0][HVDimension-1:0]     rsp_b_o,
    output logic                                   im_port_a_cim_o,
    output logic [ImAddrWidth-1:0]                 im_a_addr_o,
    output logic [ImAddrWidth-1:0]                 im_b_addr_o,
    input  logic [HVDimension-1:0]                 im_a_i,
    input  logic [HVDimension-1:0]                 im_b_i,
    output logic                                   busy_o,
    output logic [CntWidth-1:0]                    lookup_cnt_o
);

    logic [NumReq-1:0]                  eligible;
    logic [NumReq-1:0]                  gnt;
    im_req_t                            sel_req;
    logic                               unused_sel_bits;

    logic [NumReq-1:0]                  rsp_valid_q, rsp_valid_d;
    logic [NumReq-1:0][HVDimension-1:0] rsp_a_q, rsp_a_d;
    logic [NumReq-1:0][HVDimension-1:0] rsp_b_q, rsp_b_d;
    logic [CntWidth-1:0]                cnt_q, cnt_d;

    // Reset masks eligibility, so no grant appears and the memory lines stay
    // zero while rst_i is high.
    always_comb begin
        eligible = '0;
        if (en_i && !rst_i) begin
            eligible = req_valid_i & (~rsp_valid_q | rsp_ready_i);
        end
    end

    rr_arbiter #(
        .NumReq (NumReq)
    ) u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (eligible),
        .gnt_o (gnt)
    );

    // Route the granted request to the memory. Everything is zero when there
    // is no grant.
    always_comb begin
        sel_req = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (gnt[i]) begin
                sel_req.cim    = req_cim_i[i];
                sel_req.a_addr = ImAddrMaxWidth'(req_a_addr_i[i]);
                sel_req.b_addr = ImAddrMaxWidth'(req_b_addr_i[i]);
            end
        end
    end

    // The upper address bits of the struct are zero by construction.
    assign unused_sel_bits = ^sel_req;

    assign im_port_a_cim_o = sel_req.cim;
    assign im_a_addr_o     = sel_req.a_addr[ImAddrWidth-1:0];
    assign im_b_addr_o     = sel_req.b_addr[ImAddrWidth-1:0];

    // A grant loads new data, and it takes precedence over a same-cycle
    // drain. The data registers are left untouched on a drain.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_a_d     = rsp_a_q;
        rsp_b_d     = rsp_b_q;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (gnt[i]) begin
                rsp_valid_d[i] = 1'b1;
                rsp_a_d[i]     = im_a_i;
                rsp_b_d[i]     = im_b_i;
            end else if (rsp_valid_q[i] && rsp_ready_i[i]) begin
                rsp_valid_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if ((|gnt) && (cnt_q != {CntWidth{1'b1}})) begin
            cnt_d = cnt_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= '0;
            rsp_a_q     <= '0;
            rsp_b_q     <= '0;
            cnt_q       <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_a_q     <= rsp_a_d;
            rsp_b_q     <= rsp_b_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_ready_o  = gnt;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_a_o      = rsp_a_q;
    assign rsp_b_o      = rsp_b_q;
    assign lookup_cnt_o = cnt_q;
    assign busy_o       = (|rsp_valid_q) || (|eligible);

endmodule

// File: tb/tb_im_req_scheduler.sv
// Directed, table-driven bench for im_req_scheduler. It uses two requesters,
// 64-bit hypervectors, a 16-entry item memory and a 4-bit lookup counter so
// that counter saturation is reachable.
module tb_im_req_scheduler;

    localparam int unsigned HvW  = 64;
    localparam int unsigned AddW = 4;
    localparam int unsigned CntW = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      en;
    logic [1:0]                req_valid;
    logic [1:0]                req_ready;
    logic [1:0]                req_cim;
    logic [1:0][AddW-1:0]      req_a_addr;
    logic [1:0][AddW-1:0]      req_b_addr;
    logic [1:0]                rsp_valid;
    logic [1:0]                rsp_ready;
    logic [1:0][HvW-1:0]       rsp_a;
    logic [1:0][HvW-1:0]       rsp_b;
    logic                      im_cim;
    logic [AddW-1:0]           im_a_addr;
    logic [AddW-1:0]           im_b_addr;
    logic [HvW-1:0]            im_a;
    logic [HvW-1:0]            im_b;
    logic                      busy;
    logic [CntW-1:0]           lookup_cnt;

    int total = 0;
    int bad   = 0;

    logic [HvW-1:0] exp_a [2];
    logic [HvW-1:0] exp_b [2];

    typedef struct {
        logic       en;
        logic [1:0] valid;
        logic [1:0] rdy;
        logic [1:0] cim;
        logic [3:0] a0;
        logic [3:0] b0;
        logic [3:0] a1;
        logic [3:0] b1;
        logic [1:0] gnt;
        logic       busy;
        logic [1:0] rv;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs [16];

    im_req_scheduler #(
        .HVDimension (HvW),
        .NumTotIm    (16),
        .NumReq      (2),
        .CntWidth    (CntW)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .en_i            (en),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_cim_i       (req_cim),
        .req_a_addr_i    (req_a_addr),
        .req_b_addr_i    (req_b_addr),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_a_o         (rsp_a),
        .rsp_b_o         (rsp_b),
        .im_port_a_cim_o (im_cim),
        .im_a_addr_o     (im_a_addr),
        .im_b_addr_o     (im_b_addr),
        .im_a_i          (im_a),
        .im_b_i          (im_b),
        .busy_o          (busy),
        .lookup_cnt_o    (lookup_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- item memory model ----------------
    function automatic logic [HvW-1:0] im_val(input logic [AddW-1:0] x);
        return 64'h0123_4567_89AB_CDEF ^ ({60'd0, x} * 64'h1111_1111_1111_1111);
    endfunction

    function automatic logic [HvW-1:0] cim_val(input logic [AddW-1:0] x);
        return {32'hC1C1_C1C1, 28'd0, x};
    endfunction

    always_comb begin
        im_a = im_cim ? cim_val(im_a_addr) : im_val(im_a_addr);
        im_b = im_val(im_b_addr);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_rsp(input string tag);
        check($sformatf("%s.rsp_a0", tag), rsp_a[0], exp_a[0]);
        check($sformatf("%s.rsp_a1", tag), rsp_a[1], exp_a[1]);
        check($sformatf("%s.rsp_b0", tag), rsp_b[0], exp_b[0]);
        check($sformatf("%s.rsp_b1", tag), rsp_b[1], exp_b[1]);
    endtask

    // ---------------- driver ----------------
    // Drive on the falling edge, check the combinational outputs 1 time unit
    // later, then check the registered outputs 1 time unit after the rising edge.
    task automatic apply(input vec_t v, input string tag);
        logic [3:0] ea, eb;
        logic       ecim;
        @(negedge clk);
        en            = v.en;
        req_valid     = v.valid;
        rsp_ready     = v.rdy;
        req_cim       = v.cim;
        req_a_addr[0] = v.a0;
        req_b_addr[0] = v.b0;
        req_a_addr[1] = v.a1;
        req_b_addr[1] = v.b1;
        #1;
        ecim = 1'b0;
        ea   = '0;
        eb   = '0;
        if (v.gnt[0]) begin
            ecim = v.cim[0]; ea = v.a0; eb = v.b0;
        end else if (v.gnt[1]) begin
            ecim = v.cim[1]; ea = v.a1; eb = v.b1;
        end
        check($sformatf("%s.gnt", tag),    64'(req_ready), 64'(v.gnt));
        check($sformatf("%s.im_cim", tag), 64'(im_cim),    64'(ecim));
        check($sformatf("%s.im_a", tag),   64'(im_a_addr), 64'(ea));
        check($sformatf("%s.im_b", tag),   64'(im_b_addr), 64'(eb));
        check($sformatf("%s.busy", tag),   64'(busy),      64'(v.busy));
        if (v.gnt[0]) begin
            exp_a[0] = v.cim[0] ? cim_val(v.a0) : im_val(v.a0);
            exp_b[0] = im_val(v.b0);
        end
        if (v.gnt[1]) begin
            exp_a[1] = v.cim[1] ? cim_val(v.a1) : im_val(v.a1);
            exp_b[1] = im_val(v.b1);
        end
        @(posedge clk);
        #1;
        check($sformatf("%s.rsp_valid", tag), 64'(rsp_valid),  64'(v.rv));
        check($sformatf("%s.cnt", tag),       64'(lookup_cnt), 64'(v.cnt));
        check_rsp(tag);
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t       v;
        logic [3:0] c;

        //            en  valid  rdy    cim    a0  b0  a1  b1  gnt    busy rv     cnt
        vecs[0]  = '{1'b1, 2'b01, 2'b00, 2'b00, 5,  9,  0,  0,  2'b01, 1'b1, 2'b01, 1};
        vecs[1]  = '{1'b1, 2'b00, 2'b01, 2'b00, 0,  0,  0,  0,  2'b00, 1'b1, 2'b00, 1};
        vecs[2]  = '{1'b1, 2'b11, 2'b11, 2'b00, 1,  2,  3,  4,  2'b10, 1'b1, 2'b10, 2};
        vecs[3]  = '{1'b1, 2'b11, 2'b11, 2'b00, 6,  7,  8,  10, 2'b01, 1'b1, 2'b01, 3};
        vecs[4]  = '{1'b1, 2'b11, 2'b11, 2'b00, 11, 12, 13, 14, 2'b10, 1'b1, 2'b10, 4};
        vecs[5]  = '{1'b1, 2'b11, 2'b11, 2'b00, 2,  3,  4,  5,  2'b01, 1'b1, 2'b01, 5};
        vecs[6]  = '{1'b1, 2'b10, 2'b01, 2'b00, 0,  0,  15, 1,  2'b10, 1'b1, 2'b10, 6};
        vecs[7]  = '{1'b1, 2'b11, 2'b00, 2'b00, 7,  8,  9,  9,  2'b01, 1'b1, 2'b11, 7};
        vecs[8]  = '{1'b1, 2'b11, 2'b00, 2'b00, 1,  1,  2,  2,  2'b00, 1'b1, 2'b11, 7};
        vecs[9]  = '{1'b1, 2'b11, 2'b10, 2'b00, 4,  4,  12, 6,  2'b10, 1'b1, 2'b11, 8};
        vecs[10] = '{1'b0, 2'b11, 2'b11, 2'b00, 5,  5,  5,  5,  2'b00, 1'b1, 2'b00, 8};
        vecs[11] = '{1'b0, 2'b11, 2'b00, 2'b00, 6,  6,  6,  6,  2'b00, 1'b0, 2'b00, 8};
        vecs[12] = '{1'b1, 2'b01, 2'b00, 2'b01, 3,  5,  0,  0,  2'b01, 1'b1, 2'b01, 9};
        vecs[13] = '{1'b1, 2'b10, 2'b00, 2'b10, 0,  0,  2,  7,  2'b10, 1'b1, 2'b11, 10};
        vecs[14] = '{1'b1, 2'b00, 2'b11, 2'b00, 0,  0,  0,  0,  2'b00, 1'b1, 2'b00, 10};
        vecs[15] = '{1'b1, 2'b00, 2'b11, 2'b00, 0,  0,  0,  0,  2'b00, 1'b0, 2'b00, 10};

        exp_a[0] = '0; exp_a[1] = '0;
        exp_b[0] = '0; exp_b[1] = '0;

        // ---- initial reset: requests present but must not be granted ----
        rst = 1'b1; en = 1'b1; req_valid = 2'b11; rsp_ready = 2'b00;
        req_cim = 2'b11; req_a_addr = '{4'd7, 4'd7}; req_b_addr = '{4'd3, 4'd3};
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.gnt",    64'(req_ready), 64'd0);
        check("rst.im_a",   64'(im_a_addr), 64'd0);
        check("rst.im_b",   64'(im_b_addr), 64'd0);
        check("rst.im_cim", 64'(im_cim),    64'd0);
        check("rst.rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst.cnt",       64'(lookup_cnt), 64'd0);
        check_rsp("rst");
        rst = 1'b0; req_valid = 2'b00; req_cim = 2'b00;

        // ---- table ----
        for (int i = 0; i < 16; i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // ---- counter saturation: keep both requesters busy with
        //      alternating grants ----
        c = 4'd10;
        for (int k = 0; k < 8; k++) begin
            v.en = 1'b1; v.valid = 2'b11; v.rdy = 2'b11; v.cim = 2'b00;
            v.a0 = 4'(k); v.b0 = 4'(k + 1); v.a1 = 4'(k + 2); v.b1 = 4'(k + 3);
            v.gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
            v.busy = 1'b1;
            v.rv = v.gnt;
            c = (c == 4'hF) ? c : c + 4'd1;
            v.cnt = c;
            apply(v, $sformatf("sat%0d", k));
        end

        // ---- fill both buffers so that requester 0 was granted last ----
        v = '{1'b0, 2'b00, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 1'b1, 2'b00, 15};
        apply(v, "drain");
        v = '{1'b1, 2'b10, 2'b00, 2'b00, 0, 0, 9, 3, 2'b10, 1'b1, 2'b10, 15};
        apply(v, "fill1");
        v = '{1'b1, 2'b01, 2'b00, 2'b00, 4, 8, 0, 0, 2'b01, 1'b1, 2'b11, 15};
        apply(v, "fill0");

        // ---- reset in the middle of operation discards both buffers ----
        @(negedge clk);
        rst = 1'b1; en = 1'b1; req_valid = 2'b11; rsp_ready = 2'b00;
        #1;
        check("mrst.gnt",  64'(req_ready), 64'd0);
        check("mrst.im_a", 64'(im_a_addr), 64'd0);
        check("mrst.im_b", 64'(im_b_addr), 64'd0);
        @(posedge clk);
        #1;
        exp_a[0] = '0; exp_a[1] = '0;
        exp_b[0] = '0; exp_b[1] = '0;
        check("mrst.rsp_valid", 64'(rsp_valid),  64'd0);
        check("mrst.cnt",       64'(lookup_cnt), 64'd0);
        check_rsp("mrst");
        @(negedge clk);
        rst = 1'b0; req_valid = 2'b00;
        // The pointer was at requester 0 before reset. Requester 0 still wins
        // first here, which shows that reset restored the pointer.
        v = '{1'b1, 2'b11, 2'b00, 2'b00, 2, 6, 5, 1, 2'b01, 1'b1, 2'b01, 1};
        apply(v, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/im_req_scheduler.md
IM_REQ_SCHEDULER -- requirements
Module: im_req_scheduler

Interface
REQ-001 SHALL have parameter HVDimension, default 512, hypervector width.
REQ-002 SHALL have parameter NumTotIm, default 1024, total item-memory entries; ImAddrWidth = $clog2(NumTotIm).
REQ-003 SHALL have parameter NumReq, default 2, number of requesters (legal range 2..8).
REQ-004 SHALL have parameter CntWidth, default 32, lookup-counter width.
REQ-005 SHALL have ports:
- clk_i  in  1  the only clock; reset is synchronous and active-high.
- rst_i  in  1  synchronous active-high reset.
- en_i  in  1  grant enable.
- req_valid_i  in  NumReq  request valid per requester.
- req_ready_o  out  NumReq  request accepted (granted) this cycle.
- req_cim_i  in  NumReq  port A reads CiM instead of IM.
- req_a_addr_i  in  NumReq x ImAddrWidth  port A address.
- req_b_addr_i  in  NumReq x ImAddrWidth  port B address.
- rsp_valid_o  out  NumReq  response buffer full.
- rsp_ready_i  in  NumReq  response consumed.
- rsp_a_o  out  NumReq x HVDimension  buffered port A HV.
- rsp_b_o  out  NumReq x HVDimension  buffered port B HV.
- im_port_a_cim_o  out  1  to item memory CiM select.
- im_a_addr_o  out  ImAddrWidth  to item memory port A address.
- im_b_addr_o  out  ImAddrWidth  to item memory port B address.
- im_a_i  in  HVDimension  item memory port A data (combinational).
- im_b_i  in  HVDimension  item memory port B data (combinational).
- busy_o  out  1  any rsp_valid_o set or any eligible request.
- lookup_cnt_o  out  CntWidth  total granted lookups.

Function
REQ-006 Requester i SHALL be eligible when en_i & req_valid_i[i] & (~rsp_valid_o[i] | rsp_ready_i[i]).
REQ-007 At most one requester SHALL be granted per cycle; req_ready_o SHALL be one-hot or zero.
REQ-008 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NumReq; last_grant updates only on a grant.
REQ-009 During a grant, im_port_a_cim_o/im_a_addr_o/im_b_addr_o SHALL combinationally equal the granted requester's req_cim_i/req_a_addr_i/req_b_addr_i; with no grant they SHALL be all zero.
REQ-010 On a grant to i, rsp_a_o[i]/rsp_b_o[i] SHALL load im_a_i/im_b_i at that clock edge and rsp_valid_o[i] SHALL be 1 the next cycle (latency 1 cycle).
REQ-011 rsp_valid_o[i] SHALL clear after a cycle with rsp_valid_o[i] & rsp_ready_i[i] and no new grant to i; simultaneous drain and grant SHALL keep it 1 with new data.
REQ-012 rsp_a_o/rsp_b_o SHALL hold value while rsp_valid_o is 1 and rsp_ready_i is 0.
REQ-013 rsp_ready_i while rsp_valid_o is 0 SHALL have no effect.
REQ-014 en_i low SHALL block new grants only; full buffers still drain.
REQ-015 lookup_cnt_o SHALL increment by 1 per grant and saturate at all-ones.
REQ-016 Request fields SHALL be sampled only in the grant cycle; changing them while not granted is legal.

Reset
REQ-017 With rst_i high at a clock edge: rsp_valid_o=0, rsp_a_o/rsp_b_o=0, last_grant=NumReq-1 (so requester 0 has first priority), lookup_cnt_o=0.
REQ-018 While rst_i is high, req_ready_o SHALL be 0 and im_*_o SHALL be zero; reset mid-operation SHALL discard buffered responses.

Structure
REQ-019 A shared package SHALL hold the request struct (cim, a_addr, b_addr) and default HVDimension/NumTotIm constants.
REQ-020 The round-robin arbiter SHALL be a sub-module rr_arbiter (NumReq in, one-hot grant out, pointer internal); item_memory SHALL remain external.

Verification
REQ-021 Reset, then req 0 valid addr A=5 B=9 cim=0 -> grant cycle 1, im_a_addr_o=5, rsp_valid_o[0]=1 cycle 2 with rsp_a_o=IM[5], lookup_cnt_o=1.
REQ-022 Both requesters valid every cycle, rsp_ready_i=all 1 -> grants alternate 0,1,0,1; lookup_cnt_o=4 after 4 cycles.
REQ-023 Req 1 buffer full, rsp_ready_i[1]=0, both valid -> only req 0 granted; rsp_b_o[1] stable; raise rsp_ready_i[1] -> req 1 granted same cycle, rsp_valid_o[1] stays 1 with new data.
REQ-024 cim=1, A addr=3 -> im_port_a_cim_o=1 in grant cycle, rsp_a_o = CiM level 3.
REQ-025 en_i=0 with valid requests and full buffers draining -> no grants, rsp_valid_o falls to 0, counter unchanged.
REQ-026 rst_i asserted with both buffers full -> next cycle rsp_valid_o=0, counter 0, first grant goes to requester 0.
